// File: rtl/game_pkg.sv
// +----------------------------------------------------------------------+
// | game_pkg: screen geometry, field widths, colours and FSM encoding    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package game_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int COLOUR_W  = 3;
  localparam int FB_ADDR_W = 15;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/plot_fifo.sv
// +----------------------------------------------------------------------+
// | plot_fifo: synchronous FIFO, separate occupancy count, async reset   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module plot_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/plot_receiver.sv
// +----------------------------------------------------------------------+
// | plot_receiver: buffers sprite plots, writes framebuffer, screen clear|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module plot_receiver #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        ready,
  output logic        oob,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready
);

  import game_pkg::*;

  localparam int ENTRY_W = FB_ADDR_W + COLOUR_W;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_e               state_q;
  logic [FB_ADDR_W-1:0] fb_addr_q;
  logic [FB_ADDR_W-1:0] sweep_q;
  logic [COLOUR_W-1:0]  fb_data_q;
  logic                 fb_we_q;
  logic                 oob_q;
  logic                 clear_busy_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_din;
  logic [ENTRY_W-1:0]   fifo_dout;

  logic                 accept;
  logic                 in_range;
  logic                 out_free;
  logic [FB_ADDR_W-1:0] x_ext;
  logic [FB_ADDR_W-1:0] y_ext;
  logic [FB_ADDR_W-1:0] lin_addr;

  assign ready    = !fifo_full && (state_q == ST_IDLE);
  assign accept   = plot && ready;
  assign in_range = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);

  // y*160 as two shifts: 160 = 128 + 32.
  assign x_ext    = FB_ADDR_W'(x);
  assign y_ext    = FB_ADDR_W'(y);
  assign lin_addr = (y_ext << 7) + (y_ext << 5) + x_ext;

  assign fifo_push = accept && in_range;
  assign fifo_din  = {lin_addr, colour};
  assign out_free  = !fb_we_q || fb_ready;
  assign fifo_pop  = !fifo_empty && out_free && (state_q != ST_CLEAR);

  plot_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      oob_q        <= 1'b0;
      clear_busy_q <= 1'b0;
      sweep_q      <= '0;
    end else begin
      oob_q <= accept && !in_range;
      case (state_q)
        ST_IDLE, ST_DRAIN: begin
          if (fifo_pop) begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= fifo_dout[ENTRY_W-1:COLOUR_W];
            fb_data_q <= fifo_dout[COLOUR_W-1:0];
          end else if (fb_ready) begin
            fb_we_q <= 1'b0;
          end
          if (state_q == ST_IDLE && clear_req) begin
            state_q      <= ST_DRAIN;
            clear_busy_q <= 1'b1;
          end
          // Drained once nothing is queued and the last plot write retires now.
          if (state_q == ST_DRAIN && fifo_empty && out_free) begin
            state_q   <= ST_CLEAR;
            sweep_q   <= '0;
            fb_we_q   <= 1'b1;
            fb_addr_q <= '0;
            fb_data_q <= CLEAR_COLOUR;
          end
        end
        ST_CLEAR: begin
          if (fb_ready) begin
            if (sweep_q == LAST_ADDR) begin
              state_q      <= ST_IDLE;
              fb_we_q      <= 1'b0;
              clear_busy_q <= 1'b0;
            end else begin
              sweep_q   <= sweep_q + FB_ADDR_W'(1);
              fb_addr_q <= sweep_q + FB_ADDR_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign oob        = oob_q;
  assign clear_busy = clear_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_plot_receiver.sv
// +----------------------------------------------------------------------+
// | tb_plot_receiver: scoreboard bench for plot_receiver                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_plot_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        ready;
  logic        oob;
  logic        clear_req;
  logic        clear_busy;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;

  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] sb[$];

  always #5 clock = ~clock;

  plot_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .ready      (ready),
    .oob        (oob),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_wr(input int xx, input int yy, input logic [2:0] c);
    return {15'(yy * 160 + xx), c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || fb_we) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb.size() != 0 || fb_we), 0);
  endtask

  // Every completed framebuffer write is matched against the scoreboard head.
  always @(negedge clock) begin
    if (fb_we === 1'b1 && fb_ready === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("fb_write", 32'({fb_addr, fb_data}), 32'(sb.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit;
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; fb_ready = 1'b1;

    #12;
    chk("rst_we",   32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_oob",  32'(oob), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 1);

    // Single plot: write appears two cycles later.
    x = 8'd3; y = 7'd2; colour = 3'b111; plot = 1'b1;
    sb.push_back(exp_wr(3, 2, 3'b111));
    tick(); plot = 1'b0;
    chk("t1_oob",    32'(oob), 0);
    chk("t1_we_k1",  32'(fb_we), 0);
    tick();
    chk("t1_we_k2",  32'(fb_we), 1);
    chk("t1_addr",   32'(fb_addr), 323);
    chk("t1_data",   32'(fb_data), 7);
    tick();
    chk("t1_we_k3",  32'(fb_we), 0);

    // Out-of-range requests.
    for (int k = 0; k < 2; k++) begin
      x = (k == 0) ? 8'd160 : 8'd0;
      y = (k == 0) ? 7'd5 : 7'd120;
      colour = 3'b101; plot = 1'b1;
      tick(); plot = 1'b0;
      chk("t2_oob_hi", 32'(oob), 1);
      chk("t2_no_we",  32'(fb_we), 0);
      tick();
      chk("t2_oob_lo", 32'(oob), 0);
      chk("t2_no_we2", 32'(fb_we), 0);
      chk("t2_ready",  32'(ready), 1);
    end

    // Back-pressure: 4 FIFO entries plus one held output.
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t3_ready", 32'(ready), (i < 5) ? 1 : 0);
      x = 8'(i); y = 7'd0; colour = 3'(i + 1); plot = 1'b1;
      if (i < 5) sb.push_back(exp_wr(i, 0, 3'(i + 1)));
      tick();
    end
    plot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_addr", 32'(fb_addr), 0);
      chk("t3_hold_we",   32'(fb_we), 1);
      tick();
    end
    fb_ready = 1'b1;
    drain(50);
    chk("t3_ready_back", 32'(ready), 1);

    // Clear with two pending plots, plus an ignored mid-clear request.
    fb_ready = 1'b0;
    x = 8'd10; y = 7'd1; colour = 3'b101; plot = 1'b1;
    sb.push_back(exp_wr(10, 1, 3'b101));
    tick();
    x = 8'd159; y = 7'd119; colour = 3'b110;
    sb.push_back(exp_wr(159, 119, 3'b110));
    tick();
    plot = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("t4_busy_start",  32'(clear_busy), 1);
    chk("t4_ready_start", 32'(ready), 0);
    tick();
    chk("t4_stall_addr", 32'(fb_addr), 170);
    for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'b000});
    fb_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 25000) begin
      chk("t4_busy",  32'(clear_busy), 1);
      chk("t4_ready", 32'(ready), 0);
      clear_req = (n == 1000);
      tick();
      n++;
    end
    clear_req = 1'b0;
    chk("t4_done",     32'(sb.size()), 0);
    chk("t4_busy_end", 32'(clear_busy), 0);
    chk("t4_we_end",   32'(fb_we), 0);
    chk("t4_ready_end", 32'(ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_idle", 32'(clear_busy), 0);
    end

    // Stalled clear, then asynchronous reset at sweep address 5000.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'b000});
    n = 0; hit = 1'b0;
    while (n < 30000) begin
      if (fb_we && fb_addr == 15'd5000) begin
        hit = 1'b1;
        break;
      end
      fb_ready  = 1'($urandom_range(0, 1));
      clear_req = (n == 50);
      tick();
      n++;
    end
    clear_req = 1'b0;
    chk("t5_reach", 32'(hit), 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_we",   32'(fb_we), 0);
    chk("t5_rst_addr", 32'(fb_addr), 0);
    chk("t5_rst_data", 32'(fb_data), 0);
    chk("t5_rst_busy", 32'(clear_busy), 0);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t5_ready", 32'(ready), 1);
    chk("t5_busy",  32'(clear_busy), 0);
    fb_ready = 1'b1;
    x = 8'd7; y = 7'd3; colour = 3'b011; plot = 1'b1;
    sb.push_back(exp_wr(7, 3, 3'b011));
    tick();
    plot = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
